multiplier_r16: RTL

MULTIPLIER_R16 -- requirements
Module: multiplier_r16

---
 rtl/multiplier_r16_pkg.sv | 21 ++
 rtl/multiplier_r16_booth_r16_pp.sv | 42 ++++
 rtl/multiplier_r16.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/multiplier_r16_pkg.sv
// Shared types and constants for the radix-16 Booth multiplier:
// FSM state encoding, recode window width and the digit recoder.
package multiplier_r16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Recode window: four new multiplier bits plus the previous top bit.
    localparam int DIGIT_W = 5;
    // Operands are extended by one digit so unsigned values recode correctly.
    localparam int EXT_W   = 4;

    // Window {b3,b2,b1,b0,b_prev} -> d = -8*b3 + 4*b2 + 2*b1 + b0 + b_prev.
    function automatic logic signed [4:0] booth_digit(input logic [DIGIT_W-1:0] win);
        booth_digit = $signed({win[4], win[4:1]}) + $signed({4'b0000, win[0]});
    endfunction

endpackage

// File: rtl/multiplier_r16_booth_r16_pp.sv
// Radix-16 Booth partial-product generator: recodes a 5-bit window to a digit
// in -8..+8 and returns d*multiplicand as a WIDTH+8 bit two's-complement value.
module booth_r16_pp
    import multiplier_r16_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [DIGIT_W-1:0]     window_i,
    input  logic [WIDTH+EXT_W-1:0] mcand_i,
    output logic [WIDTH+7:0]       pp_o
);

    localparam int PW = WIDTH + 8;

    logic signed [4:0] digit;
    logic              neg;
    logic [3:0]        mag;
    logic [PW-1:0]     m1;
    logic [PW-1:0]     mag_pp;

    always_comb begin
        digit = booth_digit(window_i);
        neg   = digit[4];
        // |-8| = 8 still fits in four unsigned bits.
        mag   = neg ? 4'(-digit) : digit[3:0];
        m1    = {{4{mcand_i[WIDTH+EXT_W-1]}}, mcand_i};
        case (mag)
            4'd0:    mag_pp = '0;
            4'd1:    mag_pp = m1;
            4'd2:    mag_pp = m1 << 1;
            4'd3:    mag_pp = (m1 << 1) + m1;
            4'd4:    mag_pp = m1 << 2;
            4'd5:    mag_pp = (m1 << 2) + m1;
            4'd6:    mag_pp = (m1 << 2) + (m1 << 1);
            4'd7:    mag_pp = (m1 << 3) - m1;
            4'd8:    mag_pp = m1 << 3;
            default: mag_pp = '0;
        endcase
        pp_o = neg ? -mag_pp : mag_pp;
    end

endmodule

// File: rtl/multiplier_r16.sv
// Sequential radix-16 Booth multiplier: one digit per EXEC cycle, signed or
// unsigned operands, registered 2*WIDTH product presented in DONE.
module multiplier_r16
    import multiplier_r16_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               op_done,
    output state_t             dbg_state
);

    localparam int XW   = WIDTH + EXT_W;
    localparam int AW   = WIDTH + 8;
    localparam int NDIG = WIDTH / 4 + 1;
    localparam int CW   = $clog2(NDIG + 1);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
        $error("multiplier_r16: WIDTH must be a multiple of 4 and at least 8");
    end

    state_t             state_q, state_d;
    logic [CW-1:0]      iter_q, iter_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [XW-1:0]      mplr_q, mplr_d;
    logic [XW-1:0]      mcand_q, mcand_d;
    logic               prev_q, prev_d;
    logic               signed_q, signed_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic          start_ok;
    logic [CW-1:0] last_iter;
    logic          last_digit;
    logic [AW-1:0] pp;
    logic [AW-1:0] sum;
    logic [AW-1:0] acc_shift;
    logic [XW-1:0] mplr_shift;

    booth_r16_pp #(.WIDTH(WIDTH)) u_pp (
        .window_i (({mplr_q[3:0], prev_q})),
        .mcand_i  (mcand_q),
        .pp_o     (pp)
    );

    assign start_ok   = op_start && (state_q == IDLE || state_q == DONE);
    // Unsigned operands need the extra zero-extension digit.
    assign last_iter  = signed_q ? CW'(WIDTH / 4 - 1) : CW'(WIDTH / 4);
    assign last_digit = (state_q == EXEC) && (iter_q == last_iter);
    assign sum        = acc_q + pp;
    assign acc_shift  = {{4{sum[AW-1]}}, sum[AW-1:4]};
    assign mplr_shift = {sum[3:0], mplr_q[XW-1:4]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (op_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (op_start) state_d = EXEC;
                EXEC:    if (last_digit) state_d = DONE;
                DONE:    if (op_start) state_d = EXEC;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy      = (state_q == EXEC);
        op_done   = (state_q == DONE);
        result    = result_q;
        dbg_state = state_q;
    end

    // Datapath next-state: operand capture, digit accumulate/shift, product latch.
    always_comb begin
        iter_d   = iter_q;
        acc_d    = acc_q;
        mplr_d   = mplr_q;
        mcand_d  = mcand_q;
        prev_d   = prev_q;
        signed_d = signed_q;
        result_d = result_q;
        if (op_clear) begin
            iter_d   = '0;
            acc_d    = '0;
            result_d = '0;
        end else if (start_ok) begin
            signed_d = is_signed;
            mcand_d  = {{EXT_W{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
            mplr_d   = {{EXT_W{is_signed & multiplier[WIDTH-1]}}, multiplier};
            acc_d    = '0;
            prev_d   = 1'b0;
            iter_d   = '0;
        end else if (state_q == EXEC) begin
            acc_d  = acc_shift;
            mplr_d = mplr_shift;
            prev_d = mplr_q[3];
            iter_d = iter_q + CW'(1);
            // Low product bits have been shifted into the multiplier register.
            if (last_digit) begin
                if (signed_q) begin
                    result_d = {acc_shift[WIDTH-1:0], mplr_shift[XW-1:4]};
                end else begin
                    result_d = {acc_shift[WIDTH-5:0], mplr_shift};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iter_q   <= '0;
            acc_q    <= '0;
            mplr_q   <= '0;
            mcand_q  <= '0;
            prev_q   <= 1'b0;
            signed_q <= 1'b0;
            result_q <= '0;
        end else begin
            iter_q   <= iter_d;
            acc_q    <= acc_d;
            mplr_q   <= mplr_d;
            mcand_q  <= mcand_d;
            prev_q   <= prev_d;
            signed_q <= signed_d;
            result_q <= result_d;
        end
    end

endmodule
